// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
package full_adder_pkg;

   localparam int FA_DEFAULT_WIDTH = 4;

   // Result layout at the default width; the top declares a WIDTH-sized twin.
   typedef struct packed {
      logic [FA_DEFAULT_WIDTH-1:0] sum;
      logic                        cout;
   } result_t;

endpackage

// File: rtl/full_adder_4bit_fa_cell.sv
// One-bit combinational full adder cell, chained by full_adder_4bit.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder_4bit.sv
// Registered WIDTH-bit ripple-carry adder with optional carry chaining.
// Define FULL_ADDER_4BIT_OVF_EN to add the registered signed-overflow output ovf.
module full_adder_4bit
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             chain_en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
`ifdef FULL_ADDER_4BIT_OVF_EN
   ,
   output logic             ovf
`endif
);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
   } result_w_t;

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   result_w_t        w_result;
   result_w_t        r_result;
   logic             r_outValid;

   // Chaining reuses the registered carry, so an idle gap keeps it alive.
   assign w_carry[0] = chain_en ? r_result.cout : cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_cell (
         .a  (a[i]),
         .b  (b[i]),
         .ci (w_carry[i]),
         .s  (w_sum[i]),
         .co (w_carry[i+1])
      );
   end

   assign w_result.sum  = w_sum;
   assign w_result.cout = w_carry[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result   <= '0;
         r_outValid <= 1'b0;
      end else if (in_valid) begin
         r_result   <= w_result;
         r_outValid <= 1'b1;
      end else begin
         r_outValid <= 1'b0;
      end
   end

   assign sum       = r_result.sum;
   assign cout      = r_result.cout;
   assign out_valid = r_outValid;

`ifdef FULL_ADDER_4BIT_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (in_valid) begin
         r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
      end
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder_4bit.sv
// Directed self-checking bench for full_adder_4bit at WIDTH=4.
module tb_full_adder_4bit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       chain_en;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [3:0] sum;
   logic       cout;
   logic       out_valid;
`ifdef FULL_ADDER_4BIT_OVF_EN
   logic       ovf;
`endif

   int compared   = 0;
   int mismatched = 0;

   full_adder_4bit #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .chain_en  (chain_en),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid)
`ifdef FULL_ADDER_4BIT_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic ch, input logic [3:0] ia,
                        input logic [3:0] ib, input logic ic);
      in_valid = v;
      chain_en = ch;
      a        = ia;
      b        = ib;
      cin      = ic;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      #2;
      compared++;
      if (sum !== 4'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_sum: got %h expected 0", sum);
      end
      compared++;
      if (cout !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_cout: got %b expected 0", cout);
      end
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      end
`ifdef FULL_ADDER_4BIT_OVF_EN
      compared++;
      if (ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_ovf: got %b expected 0", ovf);
      end
`endif
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_zero();
      drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      step();
      compared++;
      if ({out_valid, cout, sum} !== 6'b10_0000) begin
         mismatched++;
         $display("[TB] FAIL zero_add: got v=%b c=%b s=%h expected v=1 c=0 s=0",
                  out_valid, cout, sum);
      end
   endtask

   task automatic test_chain();
      drive(1'b1, 1'b0, 4'hF, 4'h1, 1'b0);
      step();
      compared++;
      if ({cout, sum} !== 5'h10) begin
         mismatched++;
         $display("[TB] FAIL chain_low: got c=%b s=%h expected c=1 s=0", cout, sum);
      end
      drive(1'b1, 1'b1, 4'h1, 4'h0, 1'b0);
      step();
      compared++;
      if ({cout, sum} !== 5'h02) begin
         mismatched++;
         $display("[TB] FAIL chain_high: got c=%b s=%h expected c=0 s=2", cout, sum);
      end
      // 0x9C + 0x7B = 0x117 built from two chained nibbles
      drive(1'b1, 1'b0, 4'hC, 4'hB, 1'b0);
      step();
      compared++;
      if ({cout, sum} !== 5'h17) begin
         mismatched++;
         $display("[TB] FAIL multiword_lo: got c=%b s=%h expected c=1 s=7", cout, sum);
      end
      drive(1'b1, 1'b1, 4'h9, 4'h7, 1'b0);
      step();
      compared++;
      if ({cout, sum} !== 5'h11) begin
         mismatched++;
         $display("[TB] FAIL multiword_hi: got c=%b s=%h expected c=1 s=1", cout, sum);
      end
   endtask

   task automatic test_hold();
      drive(1'b1, 1'b0, 4'hF, 4'hF, 1'b1);
      step();
      compared++;
      if ({out_valid, cout, sum} !== 6'b11_1111) begin
         mismatched++;
         $display("[TB] FAIL wrap_all_ones: got v=%b c=%b s=%h expected v=1 c=1 s=f",
                  out_valid, cout, sum);
      end
      drive(1'b0, 1'b0, 4'h3, 4'h5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         compared++;
         if ({out_valid, cout, sum} !== 6'b01_1111) begin
            mismatched++;
            $display("[TB] FAIL idle_hold[%0d]: got v=%b c=%b s=%h expected v=0 c=1 s=f",
                     i, out_valid, cout, sum);
         end
      end
      drive(1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
      step();
      compared++;
      if ({out_valid, cout, sum} !== 6'b10_0001) begin
         mismatched++;
         $display("[TB] FAIL chain_after_idle: got v=%b c=%b s=%h expected v=1 c=0 s=1",
                  out_valid, cout, sum);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 1'b0, 4'hF, 4'h1, 1'b0);
      step();
      compared++;
      if (cout !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL pre_reset_cout: got %b expected 1", cout);
      end
      #2;
      rst_n = 1'b0;
      #1;
      compared++;
      if ({out_valid, cout, sum} !== 6'b00_0000) begin
         mismatched++;
         $display("[TB] FAIL async_reset: got v=%b c=%b s=%h expected v=0 c=0 s=0",
                  out_valid, cout, sum);
      end
      step();
      rst_n = 1'b1;
      // cin=1 is ignored while chaining, so a stale carry would show up as 8
      drive(1'b1, 1'b1, 4'h3, 4'h4, 1'b1);
      step();
      compared++;
      if ({out_valid, cout, sum} !== 6'b10_0111) begin
         mismatched++;
         $display("[TB] FAIL chain_after_reset: got v=%b c=%b s=%h expected v=1 c=0 s=7",
                  out_valid, cout, sum);
      end
   endtask

`ifdef FULL_ADDER_4BIT_OVF_EN
   task automatic test_ovf();
      drive(1'b1, 1'b0, 4'h7, 4'h1, 1'b0);
      step();
      compared++;
      if ({ovf, cout, sum} !== 6'b10_1000) begin
         mismatched++;
         $display("[TB] FAIL ovf_pos: got o=%b c=%b s=%h expected o=1 c=0 s=8",
                  ovf, cout, sum);
      end
      drive(1'b1, 1'b0, 4'hF, 4'h1, 1'b0);
      step();
      compared++;
      if ({ovf, cout, sum} !== 6'b01_0000) begin
         mismatched++;
         $display("[TB] FAIL ovf_none: got o=%b c=%b s=%h expected o=0 c=1 s=0",
                  ovf, cout, sum);
      end
   endtask
`endif

   task automatic test_sweep();
      logic [4:0] expected;
      for (int i = 0; i < 512; i++) begin
         drive(1'b1, 1'b0, 4'(i >> 5), 4'(i >> 1), i[0]);
         expected = 5'(i >> 5) + 5'((i >> 1) & 15) + 5'(i & 1);
         step();
         compared++;
         if ({out_valid, cout, sum} !== {1'b1, expected}) begin
            mismatched++;
            $display("[TB] FAIL sweep a=%h b=%h cin=%b: got v=%b {c,s}=%h expected v=1 {c,s}=%h",
                     a, b, cin, out_valid, {cout, sum}, expected);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_chain();
      test_hold();
      test_async_reset();
`ifdef FULL_ADDER_4BIT_OVF_EN
      test_ovf();
`endif
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/full_adder_4bit.md
Name: full_adder_4bit

Overview:
- Registered WIDTH-bit ripple-carry adder with carry-in and carry-out; default width is 4.
- Optional carry chaining feeds the previous registered carry-out back as the next carry-in, so multi-word sums can be built over successive cycles.
- Used as a small arithmetic leaf in datapaths. One clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be ≥1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- chain_en  input  1  1 = use registered cout as carry-in; 0 = use cin port
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  external carry-in
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out
- out_valid  output  1  registered result strobe

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sum=0, cout=0, out_valid=0 immediately.
  - Release is synchronous to clk.
- Effective carry-in: cin_eff = chain_en ? cout (current registered value) : cin.
- Combinational result: {c_out, s} = a + b + cin_eff.
  - Computed as a WIDTH-stage ripple of 1-bit full-adder cells.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = cin_eff; c_out = c_WIDTH.
- Rising edge with in_valid=1: sum<=s, cout<=c_out, out_valid<=1. Latency is exactly 1 cycle.
- Rising edge with in_valid=0:
  - out_valid<=0.
  - sum and cout hold their values, so a chained carry survives idle cycles.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones and cout = 1. No saturation.
- chain_en=1 immediately after reset uses cout=0 as the carry-in.
- Reset asserted mid-operation discards any pending chained carry.
- No backpressure: results are overwritten every valid cycle.

Optional Feature:
- Macro: FULL_ADDER_4BIT_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the registered two's-complement overflow: ovf = c_WIDTH ^ c_{WIDTH-1}.
  - Updated under the same in_valid rule as sum and cout.
  - Resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package full_adder_pkg holds:
  - localparam FA_DEFAULT_WIDTH = 4;
  - typedef struct {sum, cout} result_t, parameterised through WIDTH in the top.
- Sub-module fa_cell: 1-bit combinational full adder (a, b, ci -> s, co), instantiated WIDTH times in a generate loop.

Test Plan:
- Reset, then in_valid=1, a=0, b=0, cin=0, chain_en=0 -> next cycle sum=0, cout=0, out_valid=1.
- a=4'hF, b=4'h1, cin=0 -> sum=4'h0, cout=1. Then chain_en=1 with a=1, b=0 -> sum=4'h2, cout=0.
- a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1. Next: in_valid=0 for 3 cycles -> sum/cout hold, out_valid=0. Then chain_en=1 with a=0, b=0 -> sum=1.
- Assert rst_n=0 mid-sequence after cout=1 -> sum=0, cout=0, out_valid=0 without a clock edge. Then chain_en=1 with a=3, b=4 -> sum=7.
- With FULL_ADDER_4BIT_OVF_EN:
  - a=4'h7, b=4'h1 -> sum=4'h8, ovf=1.
  - a=4'hF, b=4'h1 -> ovf=0, cout=1.
- Random sweep of all 512 a/b/cin combinations with chain_en=0 -> {cout,sum} equals a+b+cin each cycle.
